mux8_rr_arbiter: RTL and testbench
==================================

# mux8_rr_arbiter

Round-robin arbiter and select controller for a shared 8:1 multiplexer datapath. Eight requesters each present a request and a DW-bit word. The block picks one requester fairly, holds the mux select stable for the whole transfer, and presents the selected word downstream under a valid/ready handshake. It sits in front of the 8:1 mux tree and owns its 3-bit select.

## Interface
Parameters:
- DW, 8, width of each requester word and of out_data.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  8  request per source; must stay high until that source's ack.
- data_in  in  8*DW  source i occupies bits [i*DW +: DW]; must be stable while req[i] is high.
- ack  out  8  one-hot, single-cycle pulse to the source whose word is accepted.
- sel  out  3  registered mux select; equals the granted source index.
- out_valid  out  1  selected word is available.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DW  data_in word of source sel (combinational from registered sel).
- out_src  out  3  same value as sel, provided for downstream tagging.
- lock  in  8  present only when MUX8_ARB_LOCK_EN is defined.

## Operation
- State machine, two states:
  - IDLE: out_valid=0.
    - If req != 0, pick the first set bit searching upward from ptr, wrapping 7→0.
    - Register the winner into sel and go to GRANT.
    - If req == 0, stay in IDLE.
  - GRANT: out_valid=1 and out_data=data_in[sel].
    - Handshake = out_valid && out_ready. On a handshake, ack[sel]=1 in the same cycle, ptr ← (sel+1) mod 8, and next state is IDLE.
    - Without a handshake, stay in GRANT: sel, out_data and out_src are held and ack=0.
- Request withdrawal: if req[sel] falls while in GRANT, this is a protocol violation.
  - The next state is IDLE and ptr is unchanged.
  - out_valid still follows the state, so it drops only in the following cycle.
  - No ack is issued if no handshake occurred that cycle.
- Only the granted source's req/data matter in GRANT. Other requests arriving meanwhile wait for the next IDLE.
- Fairness: a continuously requesting source waits at most 7 other transfers.

## Timing
- Reset values: state=IDLE, ptr=0, sel=0, out_src=0, out_valid=0, ack=8'h00. out_data = data_in[0] (follows sel=0).
- Reset asserted mid-GRANT: outputs return to their reset values immediately (asynchronously). No ack is issued.
- Latency: req rising at edge N gives sel valid and out_valid=1 after edge N+1.
- ack coincides with the handshake cycle. It is combinational from state, out_ready and sel.
- Throughput: at most one transfer per 2 cycles (GRANT → IDLE → GRANT).
- out_ready may be held low indefinitely; there is no timeout.
- Simultaneous requests: resolved by ptr only; there is no fixed priority beyond ptr.
- Wrap: a handshake on source 7 sets ptr=0.

## Configuration
- Macro MUX8_ARB_LOCK_EN.
- Defined:
  - The lock[7:0] input exists.
  - If lock[sel]=1 at a handshake, ack[sel] still pulses, but the block stays in GRANT on the same sel and ptr does not advance.
  - This gives back-to-back multi-word bursts at 1 word/cycle.
  - The first handshake with lock[sel]=0 ends the burst normally.
- Undefined: no lock port, and every handshake returns to IDLE.

## Structure
- Package mux8_arb_pkg holds:
  - NREQ=8 and SEL_W=3;
  - the state enum (ST_IDLE, ST_GRANT);
  - a next_ptr function that wraps modulo 8.
- Sub-module rr_pick8: combinational rotating priority encoder.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any, idx[2:0].
- The top module holds the FSM, ptr/sel registers and the DW-wide 8:1 output selection.

## Test plan
- Reset: assert rst mid-GRANT with out_valid=1 → same cycle out_valid=0, sel=0, ack=0. After release with req=0, out_valid stays 0.
- Single source, backpressure: req=8'h08, data_in[3]=8'hA5, out_ready low for 5 cycles →
  - out_valid=1, sel=3, out_data=A5 held, ack=0;
  - then ready=1 → ack=8'h08 for one cycle, and next cycle out_valid=0.
- Fairness/wrap: req=8'h81 held, ready=1 (acked source re-requests next cycle) → grant order 0, 7, 0, 7. ptr goes 1, 0, 1, 0. Each transfer is 2 cycles.
- All request: req=8'hFF continuous, ready=1 → out_src sequence 0..7 then 0, with no source granted twice within 8 transfers.
- Withdrawal: grant source 2 with ready=0, then drop req[2] → next cycle IDLE, no ack, ptr unchanged. Re-raising req[2] with req[5] grants 2 again.
- Lock (MUX8_ARB_LOCK_EN): source 4 with lock[4]=1 for 3 handshakes, then 0, ready=1 → ack[4] on 4 consecutive cycles, then IDLE, and ptr=5.

Source files
------------

// File: rtl/mux8_arb_pkg.sv
// mux8_arb_pkg: shared constants, FSM states and pointer wrap helper for mux8_rr_arbiter
package mux8_arb_pkg;
    localparam int NREQ  = 8;
    localparam int SEL_W = 3;
    typedef enum logic {ST_IDLE, ST_GRANT} state_t;
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] p);
        return p + SEL_W'(1);
    endfunction
endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: rotating priority encoder, first set request searching upward from ptr with wrap
import mux8_arb_pkg::*;
module rr_pick8 (
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);
    always_comb begin
        any = |req;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[ptr + SEL_W'(k)]) idx = ptr + SEL_W'(k);
    end
endmodule

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin 8:1 mux select controller with valid/ready output; MUX8_ARB_LOCK_EN adds lock bursts
import mux8_arb_pkg::*;
module mux8_rr_arbiter #(
    parameter int DW = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] data_in,
    output logic [NREQ-1:0]    ack,
    output logic [SEL_W-1:0]   sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [SEL_W-1:0]   out_src
`ifdef MUX8_ARB_LOCK_EN
    ,
    input  logic [NREQ-1:0]    lock
`endif
);
    state_t           state, state_n;
    logic [SEL_W-1:0] ptr, ptr_n, sel_n, idx;
    logic             any, hs, burst;
    rr_pick8 u_pick (.req(req), .ptr(ptr), .any(any), .idx(idx));
`ifdef MUX8_ARB_LOCK_EN
    assign burst = lock[sel];
`else
    assign burst = 1'b0;
`endif
    assign out_valid = state == ST_GRANT;
    assign hs        = out_valid && out_ready;
    assign out_src   = sel;
    assign out_data  = data_in[sel*DW +: DW];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            sel   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            sel   <= sel_n;
        end
    end
    // a handshake wins over a simultaneous request drop; a drop alone abandons the grant
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        ack     = '0;
        if (state == ST_IDLE) begin
            sel_n   = any ? idx : sel;
            state_n = any ? ST_GRANT : ST_IDLE;
        end else if (hs) begin
            ack     = NREQ'(1) << sel;
            state_n = burst ? ST_GRANT : ST_IDLE;
            ptr_n   = burst ? ptr : next_ptr(sel);
        end else if (!req[sel]) begin
            state_n = ST_IDLE;
        end
    end
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed and randomized checks of mux8_rr_arbiter against a transaction-level model
module tb_mux8_rr_arbiter;
    localparam int DW = 8;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      req = '0;
    logic [8*DW-1:0] data_in = '0;
    logic [7:0]      ack;
    logic [2:0]      sel;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   out_data;
    logic [2:0]      out_src;
    logic [7:0]      lock = '0;
    int n_vec = 0;
    int n_bad = 0;
    bit m_grant;
    int m_sel, m_ptr;
    logic [7:0] last_ack;
    int acked[$];

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .ack(ack), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src)
`ifdef MUX8_ARB_LOCK_EN
        , .lock(lock)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit lock_on(input int s);
`ifdef MUX8_ARB_LOCK_EN
        return lock[s];
`else
        return 1'b0;
`endif
    endfunction

    // compare one cycle of outputs against the model, then advance model and clock
    task automatic tick();
        logic [7:0] ea;
        #1;
        ea = (m_grant && out_ready) ? 8'(1 << m_sel) : 8'h00;
        chk("out_valid", 64'(out_valid), 64'(m_grant));
        chk("sel", 64'(sel), 64'(m_sel));
        chk("out_src", 64'(out_src), 64'(m_sel));
        chk("ack", 64'(ack), 64'(ea));
        chk("out_data", 64'(out_data), 64'(data_in[m_sel*DW +: DW]));
        last_ack = ea;
        if (ea != 0) acked.push_back(m_sel);
        if (!m_grant) begin
            for (int k = 7; k >= 0; k--)
                if (req[(m_ptr + k) % 8]) begin
                    m_sel   = (m_ptr + k) % 8;
                    m_grant = 1'b1;
                end
        end else if (out_ready) begin
            if (!lock_on(m_sel)) begin
                m_grant = 1'b0;
                m_ptr   = (m_sel + 1) % 8;
            end
        end else if (!req[m_sel]) begin
            m_grant = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_src", 64'(out_src), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_data", 64'(out_data), 64'(data_in[DW-1:0]));
        req = '0;
        out_ready = 1'b0;
        lock = '0;
        m_grant = 1'b0;
        m_sel = 0;
        m_ptr = 0;
        acked.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) data_in[i*DW +: DW] = DW'($urandom);
        do_reset();
        tick();
        tick();
        // single source with backpressure
        data_in[3*DW +: DW] = 8'hA5;
        req = 8'h08;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_data", 64'(out_data), 64'hA5);
        end
        // asynchronous reset while granted, with ready high
        out_ready = 1'b1;
        do_reset();
        tick();
        tick();
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        // backpressure release
        req = 8'h08;
        tick();
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        chk("bp_ack", 64'(acked.size()), 64'd1);
        req = 8'h00;
        tick();
        chk("bp_idle", 64'(out_valid), 64'd0);
        // fairness and wrap between sources 0 and 7
        do_reset();
        req = 8'h81;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("wrap_cnt", 64'(acked.size()), 64'd4);
        for (int i = 0; i < 4 && i < acked.size(); i++)
            chk("wrap_order", 64'(acked[i]), (i % 2 == 0) ? 64'd0 : 64'd7);
        // all sources requesting
        do_reset();
        req = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 18; i++) tick();
        chk("all_cnt", 64'(acked.size()), 64'd9);
        for (int i = 0; i < 9 && i < acked.size(); i++)
            chk("all_order", 64'(acked[i]), 64'(i % 8));
        // request withdrawal
        do_reset();
        req = 8'h04;
        tick();
        tick();
        req = 8'h00;
        tick();
        tick();
        chk("wd_noack", 64'(acked.size()), 64'd0);
        req = 8'h24;
        tick();
        tick();
        chk("wd_regrant", 64'(sel), 64'd2);
`ifdef MUX8_ARB_LOCK_EN
        // locked burst on source 4
        do_reset();
        req = 8'h10;
        out_ready = 1'b1;
        lock = 8'h10;
        tick();
        for (int i = 0; i < 3; i++) tick();
        lock = 8'h00;
        tick();
        req = 8'hFF;
        tick();
        chk("lock_cnt", 64'(acked.size()), 64'd4);
        tick();
        chk("lock_ptr", 64'(sel), 64'd5);
`endif
        // randomized traffic from well-behaved requesters
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 8; i++) begin
                if (last_ack[i]) begin
                    data_in[i*DW +: DW] = DW'($urandom);
                    req[i] = $urandom_range(1);
                end else if (!req[i] && $urandom_range(3) == 0) begin
                    data_in[i*DW +: DW] = DW'($urandom);
                    req[i] = 1'b1;
                end
            end
            out_ready = $urandom_range(2) != 0;
            lock = 8'($urandom) & 8'($urandom);
            if (m_grant && !out_ready && $urandom_range(15) == 0) req[m_sel] = 1'b0;
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
